// File: rtl/blob_com_scheduler.sv
// blob_com_scheduler: turns blob moment sums (label, xsum, ysum, area) into
// a clamped centroid by issuing two divides on a shared external divider.
// Small blobs are pruned without touching the divider; kept and pruned
// blobs are tallied in saturating 16-bit counters.
//
// Optional feature: define COM_TIMEOUT_EN to enable a divider watchdog that
// aborts a request after TIMEOUT cycles in a WAIT state with no result.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request; small blobs are pruned here
// DIV_X  | one-cycle divider start with xsum / area
// WAIT_X | waiting for the x quotient
// DIV_Y  | one-cycle divider start with ysum / area
// WAIT_Y | waiting for the y quotient
// OUTPUT | result held on com_* until the consumer takes it

module blob_com_scheduler #(
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 180,
  parameter int MIN_AREA = 50,
  parameter int TIMEOUT  = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       clear_in,
  input  logic                       req_valid_in,
  output logic                       req_ready_out,
  input  logic [15:0]                req_label_in,
  input  logic [23:0]                req_xsum_in,
  input  logic [23:0]                req_ysum_in,
  input  logic [15:0]                req_area_in,
  output logic [23:0]                div_dividend_out,
  output logic [15:0]                div_divisor_out,
  output logic                       div_valid_out,
  input  logic [23:0]                div_quotient_in,
  input  logic                       div_valid_in,
  output logic                       com_valid_out,
  input  logic                       com_ready_in,
  output logic [15:0]                com_label_out,
  output logic [$clog2(WIDTH)-1:0]   com_x_out,
  output logic [$clog2(HEIGHT)-1:0]  com_y_out,
  output logic [15:0]                kept_count_out,
  output logic [15:0]                pruned_count_out,
  output logic                       busy_out,
  output logic                       timeout_out
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [23:0] X_MAX = 24'(WIDTH - 1);
  localparam logic [23:0] Y_MAX = 24'(HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DIV_X  = 3'd1,
    WAIT_X = 3'd2,
    DIV_Y  = 3'd3,
    WAIT_Y = 3'd4,
    OUTPUT = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       label_q, label_d;
  logic [23:0]       xsum_q, xsum_d;
  logic [23:0]       ysum_q, ysum_d;
  logic [15:0]       area_q, area_d;
  logic [15:0]       com_label_q, com_label_d;
  logic [XW-1:0]     com_x_q, com_x_d;
  logic [YW-1:0]     com_y_q, com_y_d;
  logic [15:0]       kept_q, kept_d;
  logic [15:0]       pruned_q, pruned_d;
  logic              kept_inc;
  logic              pruned_inc;
  logic              wd_expired;
  logic              wd_load;

`ifdef COM_TIMEOUT_EN
  localparam logic [15:0] WD_LOAD = 16'(TIMEOUT - 1);

  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  // Watchdog down-counter: loaded on entry to a WAIT state, terminal count 0.
  always_comb begin
    wd_d       = wd_q;
    wd_expired = 1'b0;
    if (wd_load) begin
      wd_d = WD_LOAD;
    end else if ((state_q == WAIT_X) || (state_q == WAIT_Y)) begin
      if (wd_q == 16'd0) begin
        wd_expired = !div_valid_in;
      end else begin
        wd_d = wd_q - 16'd1;
      end
    end
  end

  // Watchdog counter and registered abort pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_d   = wd_expired;
  assign timeout_out = timeout_q;
`else
  // Without the watchdog the WAIT states never give up; TIMEOUT is inert.
  assign wd_expired  = 1'b0;
  assign timeout_out = 1'b0 & (TIMEOUT > 0);
`endif

  // Next-state, request latching and result capture.
  always_comb begin
    state_d     = state_q;
    label_d     = label_q;
    xsum_d      = xsum_q;
    ysum_d      = ysum_q;
    area_d      = area_q;
    com_label_d = com_label_q;
    com_x_d     = com_x_q;
    com_y_d     = com_y_q;
    kept_inc    = 1'b0;
    pruned_inc  = 1'b0;
    wd_load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_in) begin
          label_d = req_label_in;
          xsum_d  = req_xsum_in;
          ysum_d  = req_ysum_in;
          area_d  = req_area_in;
          if (int'(req_area_in) < MIN_AREA) begin
            pruned_inc = 1'b1;
          end else begin
            state_d = DIV_X;
          end
        end
      end
      DIV_X: begin
        wd_load = 1'b1;
        state_d = WAIT_X;
      end
      WAIT_X: begin
        if (div_valid_in) begin
          com_x_d = (div_quotient_in > X_MAX) ? XW'(X_MAX) : div_quotient_in[XW-1:0];
          state_d = DIV_Y;
        end else if (wd_expired) begin
          state_d = IDLE;
        end
      end
      DIV_Y: begin
        wd_load = 1'b1;
        state_d = WAIT_Y;
      end
      WAIT_Y: begin
        if (div_valid_in) begin
          com_y_d     = (div_quotient_in > Y_MAX) ? YW'(Y_MAX) : div_quotient_in[YW-1:0];
          com_label_d = label_q;
          state_d     = OUTPUT;
        end else if (wd_expired) begin
          state_d = IDLE;
        end
      end
      OUTPUT: begin
        if (com_ready_in) begin
          kept_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating counters; clear overrides a coincident increment.
  always_comb begin
    kept_d   = kept_q;
    pruned_d = pruned_q;
    if (clear_in) begin
      kept_d   = 16'd0;
      pruned_d = 16'd0;
    end else begin
      if (kept_inc && (kept_q != 16'hFFFF)) kept_d = kept_q + 16'd1;
      if (pruned_inc && (pruned_q != 16'hFFFF)) pruned_d = pruned_q + 16'd1;
    end
  end

  // State, request and result registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      label_q     <= '0;
      xsum_q      <= '0;
      ysum_q      <= '0;
      area_q      <= '0;
      com_label_q <= '0;
      com_x_q     <= '0;
      com_y_q     <= '0;
      kept_q      <= '0;
      pruned_q    <= '0;
    end else begin
      state_q     <= state_d;
      label_q     <= label_d;
      xsum_q      <= xsum_d;
      ysum_q      <= ysum_d;
      area_q      <= area_d;
      com_label_q <= com_label_d;
      com_x_q     <= com_x_d;
      com_y_q     <= com_y_d;
      kept_q      <= kept_d;
      pruned_q    <= pruned_d;
    end
  end

  // Divider operands are zero except during the start pulse.
  always_comb begin
    div_valid_out    = 1'b0;
    div_dividend_out = 24'd0;
    div_divisor_out  = 16'd0;
    if (state_q == DIV_X) begin
      div_valid_out    = 1'b1;
      div_dividend_out = xsum_q;
      div_divisor_out  = area_q;
    end else if (state_q == DIV_Y) begin
      div_valid_out    = 1'b1;
      div_dividend_out = ysum_q;
      div_divisor_out  = area_q;
    end
  end

  assign req_ready_out    = (state_q == IDLE);
  assign busy_out         = (state_q != IDLE);
  assign com_valid_out    = (state_q == OUTPUT);
  assign com_label_out    = com_label_q;
  assign com_x_out        = com_x_q;
  assign com_y_out        = com_y_q;
  assign kept_count_out   = kept_q;
  assign pruned_count_out = pruned_q;

endmodule

// File: tb/tb_blob_com_scheduler.sv
// Directed bench for blob_com_scheduler with a behavioural divider whose
// result arrives a programmable number of cycles after the start pulse.
`timescale 1ns/1ps
module tb_blob_com_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        clear_in = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic [15:0] req_label_in = '0;
  logic [23:0] req_xsum_in = '0;
  logic [23:0] req_ysum_in = '0;
  logic [15:0] req_area_in = '0;
  logic [23:0] div_dividend_out;
  logic [15:0] div_divisor_out;
  logic        div_valid_out;
  logic [23:0] div_quotient_in = '0;
  logic        div_valid_in = 1'b0;
  logic        com_valid_out;
  logic        com_ready_in = 1'b1;
  logic [15:0] com_label_out;
  logic [8:0]  com_x_out;
  logic [7:0]  com_y_out;
  logic [15:0] kept_count_out;
  logic [15:0] pruned_count_out;
  logic        busy_out;
  logic        timeout_out;

  blob_com_scheduler dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .clear_in         (clear_in),
    .req_valid_in     (req_valid_in),
    .req_ready_out    (req_ready_out),
    .req_label_in     (req_label_in),
    .req_xsum_in      (req_xsum_in),
    .req_ysum_in      (req_ysum_in),
    .req_area_in      (req_area_in),
    .div_dividend_out (div_dividend_out),
    .div_divisor_out  (div_divisor_out),
    .div_valid_out    (div_valid_out),
    .div_quotient_in  (div_quotient_in),
    .div_valid_in     (div_valid_in),
    .com_valid_out    (com_valid_out),
    .com_ready_in     (com_ready_in),
    .com_label_out    (com_label_out),
    .com_x_out        (com_x_out),
    .com_y_out        (com_y_out),
    .kept_count_out   (kept_count_out),
    .pruned_count_out (pruned_count_out),
    .busy_out         (busy_out),
    .timeout_out      (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;
  int div_lat = 3;
  bit div_en = 1'b1;
  int div_pulses = 0;
  bit operand_leak = 1'b0;
  bit com_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // External divider: answers div_lat cycles after the sampling edge of the start pulse.
  always begin
    logic [23:0] q;
    @(negedge clk_in);
    if (div_valid_out && div_en) begin
      q = (div_divisor_out == 16'd0) ? 24'hFFFFFF : div_dividend_out / 24'(div_divisor_out);
      repeat (div_lat + 1) @(posedge clk_in);
      #1;
      div_valid_in    = 1'b1;
      div_quotient_in = q;
      @(posedge clk_in);
      #1;
      div_valid_in    = 1'b0;
      div_quotient_in = '0;
    end
  end

  // Monitor: start pulses, operand leakage while idle, any result seen.
  always @(negedge clk_in) begin
    if (div_valid_out) div_pulses++;
    if (!div_valid_out && ((div_dividend_out != 0) || (div_divisor_out != 0))) operand_leak = 1'b1;
    if (com_valid_out) com_seen = 1'b1;
  end

  task automatic send(input logic [15:0] lbl, input logic [23:0] xs,
                      input logic [23:0] ys, input logic [15:0] ar);
    int guard;
    guard = 0;
    while (!req_ready_out && guard < 500) begin
      @(posedge clk_in);
      #1;
      guard++;
    end
    chk("send_ready_timeout", 32'(guard < 500), 32'd1);
    req_valid_in = 1'b1;
    req_label_in = lbl;
    req_xsum_in  = xs;
    req_ysum_in  = ys;
    req_area_in  = ar;
    @(posedge clk_in);
    #1;
    req_valid_in = 1'b0;
  endtask

  // Counts edges after the accept edge until com_valid_out is seen.
  task automatic wait_com(output int lat);
    lat = 0;
    while (!com_valid_out && lat < 400) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    chk("com_valid_timeout", 32'(com_valid_out), 32'd1);
  endtask

  initial begin
    int lat;
    int p0;

    // Reset values while rst_in is low
    #12;
    chk("rst_ready", 32'(req_ready_out), 32'd1);
    chk("rst_div_valid", 32'(div_valid_out), 32'd0);
    chk("rst_com_valid", 32'(com_valid_out), 32'd0);
    chk("rst_label", 32'(com_label_out), 32'd0);
    chk("rst_x", 32'(com_x_out), 32'd0);
    chk("rst_y", 32'(com_y_out), 32'd0);
    chk("rst_kept", 32'(kept_count_out), 32'd0);
    chk("rst_pruned", 32'(pruned_count_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_timeout", 32'(timeout_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;

    // Basic centroid: 6400/100=64, 3000/100=30, latency 4+2*3
    com_ready_in = 1'b1;
    send(16'd3, 24'd6400, 24'd3000, 16'd100);
    chk("t1_busy", 32'(busy_out), 32'd1);
    chk("t1_ready_low", 32'(req_ready_out), 32'd0);
    wait_com(lat);
    chk("t1_latency", 32'(lat), 32'd10);
    chk("t1_label", 32'(com_label_out), 32'd3);
    chk("t1_x", 32'(com_x_out), 32'd64);
    chk("t1_y", 32'(com_y_out), 32'd30);
    @(posedge clk_in);
    #1;
    chk("t1_kept", 32'(kept_count_out), 32'd1);
    chk("t1_idle", 32'(busy_out), 32'd0);
    chk("t1_com_drop", 32'(com_valid_out), 32'd0);
    chk("t1_timeout", 32'(timeout_out), 32'd0);

    // Pruning at area 49 and area 0
    p0 = div_pulses;
    send(16'd4, 24'd1000, 24'd1000, 16'd49);
    chk("p49_pruned", 32'(pruned_count_out), 32'd1);
    chk("p49_ready", 32'(req_ready_out), 32'd1);
    chk("p49_busy", 32'(busy_out), 32'd0);
    send(16'd5, 24'd1000, 24'd1000, 16'd0);
    chk("p0_pruned", 32'(pruned_count_out), 32'd2);
    chk("p0_ready", 32'(req_ready_out), 32'd1);
    repeat (5) @(posedge clk_in);
    #1;
    chk("prune_no_div", 32'(div_pulses - p0), 32'd0);
    chk("prune_no_com", 32'(com_valid_out), 32'd0);
    chk("prune_kept", 32'(kept_count_out), 32'd1);

    // Clamp: 40000/50=800 -> 319, 20000/50=400 -> 179; area 50 is kept
    send(16'd9, 24'd40000, 24'd20000, 16'd50);
    wait_com(lat);
    chk("clamp_label", 32'(com_label_out), 32'd9);
    chk("clamp_x", 32'(com_x_out), 32'd319);
    chk("clamp_y", 32'(com_y_out), 32'd179);
    @(posedge clk_in);
    #1;
    chk("clamp_kept", 32'(kept_count_out), 32'd2);
    chk("clamp_pruned", 32'(pruned_count_out), 32'd2);

    // Back-pressure: 1000/100=10, 500/100=5 held for 20 cycles
    com_ready_in = 1'b0;
    send(16'd7, 24'd1000, 24'd500, 16'd100);
    wait_com(lat);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in);
      #1;
      chk("stall_valid", 32'(com_valid_out), 32'd1);
      chk("stall_label", 32'(com_label_out), 32'd7);
      chk("stall_x", 32'(com_x_out), 32'd10);
      chk("stall_y", 32'(com_y_out), 32'd5);
      chk("stall_ready", 32'(req_ready_out), 32'd0);
      chk("stall_kept", 32'(kept_count_out), 32'd2);
    end
    com_ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("stall_kept_hs", 32'(kept_count_out), 32'd3);
    chk("stall_idle", 32'(req_ready_out), 32'd1);

    // Clear coinciding with a prune increment
    clear_in = 1'b1;
    send(16'd1, 24'd0, 24'd0, 16'd10);
    clear_in = 1'b0;
    chk("clr_pruned", 32'(pruned_count_out), 32'd0);
    chk("clr_kept", 32'(kept_count_out), 32'd0);

    // Clear while a request is in flight: 2000/100=20, 900/100=9
    send(16'd11, 24'd2000, 24'd900, 16'd100);
    repeat (3) @(posedge clk_in);
    #1;
    clear_in = 1'b1;
    @(posedge clk_in);
    #1;
    clear_in = 1'b0;
    chk("clrf_busy", 32'(busy_out), 32'd1);
    wait_com(lat);
    chk("clrf_x", 32'(com_x_out), 32'd20);
    chk("clrf_y", 32'(com_y_out), 32'd9);
    @(posedge clk_in);
    #1;
    chk("clrf_kept", 32'(kept_count_out), 32'd1);

`ifdef COM_TIMEOUT_EN
    // Divider never answers: abort after 1 DIV_X cycle + 64 WAIT_X cycles
    div_en = 1'b0;
    send(16'd12, 24'd1000, 24'd1000, 16'd100);
    lat = 0;
    while (!timeout_out && lat < 300) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    chk("to_pulse", 32'(timeout_out), 32'd1);
    chk("to_cycles", 32'(lat), 32'd65);
    chk("to_idle", 32'(busy_out), 32'd0);
    chk("to_ready", 32'(req_ready_out), 32'd1);
    @(posedge clk_in);
    #1;
    chk("to_one_cycle", 32'(timeout_out), 32'd0);
    chk("to_kept", 32'(kept_count_out), 32'd1);
    chk("to_pruned", 32'(pruned_count_out), 32'd0);
    chk("to_no_com", 32'(com_valid_out), 32'd0);
    div_en = 1'b1;
`endif

    // Reset during WAIT_Y, then the late divider answer must be ignored
    p0 = div_pulses;
    send(16'd13, 24'd3000, 24'd3000, 16'd100);
    lat = 0;
    while ((div_pulses - p0) < 2 && lat < 200) begin
      @(negedge clk_in);
      lat++;
    end
    chk("rw_second_pulse", 32'(div_pulses - p0), 32'd2);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    #2;
    chk("rw_ready", 32'(req_ready_out), 32'd1);
    chk("rw_div_valid", 32'(div_valid_out), 32'd0);
    chk("rw_com_valid", 32'(com_valid_out), 32'd0);
    chk("rw_label", 32'(com_label_out), 32'd0);
    chk("rw_x", 32'(com_x_out), 32'd0);
    chk("rw_y", 32'(com_y_out), 32'd0);
    chk("rw_kept", 32'(kept_count_out), 32'd0);
    chk("rw_pruned", 32'(pruned_count_out), 32'd0);
    chk("rw_busy", 32'(busy_out), 32'd0);
    chk("rw_timeout", 32'(timeout_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    com_seen = 1'b0;
    repeat (12) @(posedge clk_in);
    #1;
    chk("rw_late_no_com", 32'(com_seen), 32'd0);
    chk("rw_late_busy", 32'(busy_out), 32'd0);
    chk("rw_late_ready", 32'(req_ready_out), 32'd1);
    chk("rw_late_kept", 32'(kept_count_out), 32'd0);

    chk("operand_zero_idle", 32'(operand_leak), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
